ham_decoder: RTL and testbench
==============================

HAM_DECODER -- requirements
Module: ham_decoder

Interface
REQ-001 Parameter CNT_W, default 8, width of corrected-error counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 in_valid  input  1  enc_ham_data is valid this cycle.
REQ-005 enc_ham_data  input  7  received Hamming(7,4) codeword; bit i-1 holds Hamming position i (i=1..7).
REQ-006 data  output  4  corrected data nibble {pos7,pos6,pos5,pos3}, registered.
REQ-007 pos_error  output  3  syndrome {s4,s2,s1}; 0 = no error, 1..7 = erroneous bit position; registered.
REQ-008 error  output  1  high when pos_error != 0; registered.
REQ-009 out_valid  output  1  data/pos_error/error hold a new result this cycle.
REQ-010 err_count  output  CNT_W  number of accepted codewords with nonzero syndrome, saturating.

Function
REQ-011 Positions 1,2,4 SHALL be even-parity bits; positions 3,5,6,7 SHALL be data bits d0,d1,d2,d3.
REQ-012 s1 SHALL be XOR of positions 1,3,5,7; s2 of 2,3,6,7; s4 of 4,5,6,7.
REQ-013 Correction SHALL invert the single bit at position = syndrome when syndrome != 0, before data extraction.
REQ-014 Parity-bit errors (syndrome 1,2,4) SHALL leave data equal to the received data bits.
REQ-015 On a rising clk edge with in_valid=1, data, pos_error, error SHALL load the decode of enc_ham_data and out_valid SHALL be 1 the following cycle (latency 1 cycle).
REQ-016 With in_valid=0, data, pos_error, error SHALL hold prior values and out_valid SHALL be 0 next cycle.
REQ-017 Back-to-back in_valid=1 SHALL produce one result per cycle, no bubbles, no back-pressure.
REQ-018 err_count SHALL increment by 1 on each accepted codeword with nonzero syndrome and SHALL saturate at 2^CNT_W-1.
REQ-019 Double-bit errors are out of scope: block SHALL treat them as single errors (miscorrection accepted, no extra flag).
REQ-020 Decode logic SHALL be purely combinational ahead of the output registers; no other internal state.

Reset
REQ-021 rst_n=0 SHALL immediately, without clk, force data=0, pos_error=0, error=0, out_valid=0, err_count=0.
REQ-022 Reset asserted mid-stream SHALL discard any in-flight result; first valid output after release appears one cycle after first accepted in_valid.
REQ-023 Outputs SHALL remain at reset values while rst_n=0 regardless of in_valid.

Verification
REQ-024 enc_ham_data=7'b1010101, in_valid=1 -> next cycle data=4'b1011, pos_error=0, error=0, out_valid=1, err_count unchanged.
REQ-025 enc_ham_data=7'b1000101 (pos5 flipped) -> data=4'b1011, pos_error=5, error=1, err_count+1.
REQ-026 enc_ham_data=7'b1010001 (pos3 flipped) -> data=4'b1011, pos_error=3, error=1; 7'b1010100 (pos1 flipped) -> data=4'b1011, pos_error=1, error=1.
REQ-027 enc_ham_data=7'b0000000 -> data=0, pos_error=0, error=0; 7'b1000000 -> data=0, pos_error=7, error=1.
REQ-028 Exhaustive: all 16 data values x 8 cases (no error, each single-bit flip) streamed back-to-back -> data always original nibble, pos_error = flipped position (or 0), err_count=112 with CNT_W=8; then 200 more error words -> err_count saturates at 255.
REQ-029 Assert rst_n=0 between clk edges during streaming -> all outputs 0 immediately; in_valid=0 cycles -> out_valid=0, data/pos_error/error held.

Source files
------------

// File: rtl/ham_decoder.sv
// rtl/ham_decoder.sv - Hamming(7,4) single-error-correcting decoder with registered outputs
// and a saturating counter of corrected codewords.
module ham_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [6:0]       enc_ham_data,
  output logic [3:0]       data,
  output logic [2:0]       pos_error,
  output logic             error,
  output logic             out_valid,
  output logic [CNT_W-1:0] err_count
);

  logic [2:0] syndrome;
  logic [6:0] flip_mask;
  logic [6:0] corrected;
  logic       cnt_full;

  // Bit i-1 of the word is Hamming position i, so each syndrome bit covers
  // the positions whose index has that binary weight set.
  always_comb begin
    syndrome[0] = enc_ham_data[0] ^ enc_ham_data[2] ^ enc_ham_data[4] ^ enc_ham_data[6];
    syndrome[1] = enc_ham_data[1] ^ enc_ham_data[2] ^ enc_ham_data[5] ^ enc_ham_data[6];
    syndrome[2] = enc_ham_data[3] ^ enc_ham_data[4] ^ enc_ham_data[5] ^ enc_ham_data[6];
    for (int i = 0; i < 7; i++) begin
      flip_mask[i] = (syndrome == 3'(i + 1));
    end
    corrected = enc_ham_data ^ flip_mask;
  end

  assign cnt_full = (err_count == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data      <= 4'd0;
      pos_error <= 3'd0;
      error     <= 1'b0;
      out_valid <= 1'b0;
      err_count <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data      <= {corrected[6], corrected[5], corrected[4], corrected[2]};
        pos_error <= syndrome;
        error     <= |syndrome;
        if (|syndrome && !cnt_full) begin
          err_count <= err_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ham_decoder.sv
// tb/tb_ham_decoder.sv - self-checking bench for ham_decoder: spec vectors, exhaustive
// single-error sweep, counter saturation, async reset and a random run against a nearest-codeword model.
module tb_ham_decoder;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [6:0]       enc_ham_data;
  logic [3:0]       data;
  logic [2:0]       pos_error;
  logic             error;
  logic             out_valid;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int passes = 0;

  // Reference state: what the outputs should be after the latest edge.
  logic [3:0] m_data;
  logic [2:0] m_pos;
  logic       m_err;
  logic       m_ov;
  int         m_cnt;

  ham_decoder #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .enc_ham_data (enc_ham_data),
    .data         (data),
    .pos_error    (pos_error),
    .error        (error),
    .out_valid    (out_valid),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] word;
    logic [3:0] exp_data;
    logic [2:0] exp_pos;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Textbook encoder: data bits at positions 3,5,6,7; parity makes each group even.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [7:0] pos;
    pos = '0;
    pos[3] = d[0]; pos[5] = d[1]; pos[6] = d[2]; pos[7] = d[3];
    pos[1] = pos[3] ^ pos[5] ^ pos[7];
    pos[2] = pos[3] ^ pos[6] ^ pos[7];
    pos[4] = pos[5] ^ pos[6] ^ pos[7];
    return pos[7:1];
  endfunction

  // The code is perfect, so every 7-bit word lies within distance 1 of exactly one codeword.
  task automatic ref_decode(input logic [6:0] w, output logic [3:0] d, output logic [2:0] p);
    logic [6:0] diff;
    d = 4'd0;
    p = 3'd0;
    for (int n = 0; n < 16; n++) begin
      diff = w ^ encode(4'(n));
      if ($countones(diff) <= 1) begin
        d = 4'(n);
        for (int b = 0; b < 7; b++) if (diff[b]) p = 3'(b + 1);
      end
    end
  endtask

  task automatic model_reset();
    m_data = 4'd0; m_pos = 3'd0; m_err = 1'b0; m_ov = 1'b0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"},      32'(data),      32'(m_data));
    chk({tag, ".pos_error"}, 32'(pos_error), 32'(m_pos));
    chk({tag, ".error"},     32'(error),     32'(m_err));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".err_count"}, 32'(err_count), 32'(m_cnt));
  endtask

  // Drive one cycle, advance the model past the edge, then compare 1 ns later.
  task automatic cycle(input logic v, input logic [6:0] w, input string tag, input bit do_chk);
    logic [3:0] d;
    logic [2:0] p;
    in_valid = v;
    enc_ham_data = w;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      m_ov = v;
      if (v) begin
        ref_decode(w, d, p);
        m_data = d; m_pos = p; m_err = (p != 0);
        if (p != 0 && m_cnt < CNT_MAX) m_cnt++;
      end
    end
    #1;
    if (do_chk) check_all(tag);
  endtask

  initial begin
    vecs[0] = '{7'b1010101, 4'b1011, 3'd0, 1'b0};
    vecs[1] = '{7'b1000101, 4'b1011, 3'd5, 1'b1};
    vecs[2] = '{7'b1010001, 4'b1011, 3'd3, 1'b1};
    vecs[3] = '{7'b1010100, 4'b1011, 3'd1, 1'b1};
    vecs[4] = '{7'b0000000, 4'b0000, 3'd0, 1'b0};
    vecs[5] = '{7'b1000000, 4'b0000, 3'd7, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; enc_ham_data = '0;
    model_reset();
    #3;
    check_all("reset_async");
    @(posedge clk); #1;
    cycle(1'b1, 7'b1111111, "reset_held", 1'b1);
    rst_n = 1'b1;

    // Spec vectors back-to-back, against the literal expected values.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, vecs[i].word, "vec", 1'b0);
      chk($sformatf("vec%0d.data", i),      32'(data),      32'(vecs[i].exp_data));
      chk($sformatf("vec%0d.pos_error", i), 32'(pos_error), 32'(vecs[i].exp_pos));
      chk($sformatf("vec%0d.error", i),     32'(error),     32'(vecs[i].exp_err));
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d.err_count", i), 32'(err_count), 32'(m_cnt));
    end

    // Idle cycles: out_valid drops, result registers hold.
    cycle(1'b0, 7'b0110011, "idle0", 1'b1);
    cycle(1'b0, 7'b1111111, "idle1", 1'b1);
    chk("idle.pos_held", 32'(pos_error), 32'd7);

    // Exhaustive single-error sweep from a fresh counter.
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("reset_mid");
    rst_n = 1'b1;
    for (int n = 0; n < 16; n++) begin
      for (int f = 0; f < 8; f++) begin
        logic [6:0] w;
        w = encode(4'(n));
        if (f != 0) w[f-1] = ~w[f-1];
        cycle(1'b1, w, "sweep", 1'b0);
        chk($sformatf("sweep_n%0d_f%0d.data", n, f), 32'(data), 32'(n));
        chk($sformatf("sweep_n%0d_f%0d.pos", n, f), 32'(pos_error), 32'(f));
        chk($sformatf("sweep_n%0d_f%0d.ov", n, f), 32'(out_valid), 32'd1);
      end
    end
    chk("sweep.err_count", 32'(err_count), 32'd112);

    for (int k = 0; k < 200; k++) begin
      logic [6:0] w;
      w = encode(4'($urandom_range(0, 15)));
      w[k % 7] = ~w[k % 7];
      cycle(1'b1, w, "sat", 1'b0);
      chk("sat.err_count", 32'(err_count), 32'(m_cnt));
    end
    chk("sat.final", 32'(err_count), 32'(CNT_MAX));

    // Async reset between edges during streaming, held with in_valid high.
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("stream_reset");
    cycle(1'b1, 7'b1000101, "reset_in_valid", 1'b1);
    #2 rst_n = 1'b1;
    cycle(1'b0, 7'b1000101, "post_reset_idle", 1'b1);
    cycle(1'b1, 7'b1000101, "post_reset_first", 1'b1);
    chk("post_reset.pos", 32'(pos_error), 32'd5);

    // Random words (including double errors) with random valid gaps.
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), 7'($urandom), "rand", 1'b1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
